puf_resp_collector: RTL

PUF_RESP_COLLECTOR -- requirements
Module: puf_resp_collector

---
 rtl/puf_pkg.sv | 16 +
 rtl/puf_vote_acc.sv | 31 +++
 rtl/puf_resp_collector.sv | 118 +++++++++++
 3 files changed

// File: rtl/puf_pkg.sv
// Shared constants and FSM state encoding for the PUF response collector.
package puf_pkg;

    localparam int RESP_W  = 32;
    localparam int MKG_W   = 4;
    localparam int NIBBLES = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SETTLE = 3'd1;
    localparam state_t ST_SAMPLE = 3'd2;
    localparam state_t ST_PACK   = 3'd3;
    localparam state_t ST_OUT    = 3'd4;

endpackage

// File: rtl/puf_vote_acc.sv
// Per-bit ones counter with majority and unanimity decode.
module puf_vote_acc #(
    parameter int VOTES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic maj,
    output logic split
);

    localparam int ONES_W = $clog2(VOTES + 1);

    logic [ONES_W-1:0] ones;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ones <= '0;
        end else if (clr) begin
            ones <= '0;
        end else if (en && bit_in) begin
            ones <= ones + 1'b1;
        end
    end

    assign maj   = ones > ONES_W'(VOTES / 2);
    assign split = (ones != '0) && (ones != ONES_W'(VOTES));

endmodule

// File: rtl/puf_resp_collector.sv
// Collects eight majority-voted MKG nibbles into one 32-bit PUF response,
// advancing the challenge source after each evaluation.
module puf_resp_collector
    import puf_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int VOTES      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MKG_W-1:0]  mkg_in,
    output logic              ch_adv,
    output logic              busy,
    output logic [RESP_W-1:0] resp_data,
    output logic              resp_flaky,
    output logic              resp_valid,
    input  logic              resp_ready
);

    localparam int MAX_CYC = (SETTLE_CYC > VOTES) ? SETTLE_CYC : VOTES;
    localparam int CYC_W   = $clog2(MAX_CYC + 1);

    state_t            state;
    state_t            state_nxt;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [3:0]        eval_cnt;
    logic [RESP_W-1:0] shift_reg;
    logic [RESP_W-1:0] shift_nxt;
    logic              flaky;
    logic              flaky_nxt;
    logic [MKG_W-1:0]  maj;
    logic [MKG_W-1:0]  split;
    logic              acc_clr;
    logic              acc_en;
    logic              accept;

    assign accept  = (state == ST_IDLE) && start;
    assign acc_clr = (state == ST_PACK) || accept;
    assign acc_en  = (state == ST_SAMPLE);

    for (genvar i = 0; i < MKG_W; i++) begin : g_vote
        puf_vote_acc #(.VOTES(VOTES)) u_acc (
            .clk    (clk),
            .rst    (rst),
            .clr    (acc_clr),
            .en     (acc_en),
            .bit_in (mkg_in[i]),
            .maj    (maj[i]),
            .split  (split[i])
        );
    end

    assign shift_nxt = {shift_reg[RESP_W-MKG_W-1:0], maj};
    assign flaky_nxt = flaky | (|split);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:
                if (start) state_nxt = ST_SETTLE;
            ST_SETTLE:
                if (cyc_cnt == CYC_W'(SETTLE_CYC - 1)) state_nxt = ST_SAMPLE;
            ST_SAMPLE:
                if (cyc_cnt == CYC_W'(VOTES - 1)) state_nxt = ST_PACK;
            ST_PACK:
                state_nxt = (eval_cnt == 4'(NIBBLES - 1)) ? ST_OUT : ST_SETTLE;
            ST_OUT:
                if (resp_ready) state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cyc_cnt    <= '0;
            eval_cnt   <= '0;
            shift_reg  <= '0;
            flaky      <= 1'b0;
            ch_adv     <= 1'b0;
            busy       <= 1'b0;
            resp_data  <= '0;
            resp_flaky <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            busy       <= state_nxt != ST_IDLE;
            ch_adv     <= state_nxt == ST_PACK;
            resp_valid <= state_nxt == ST_OUT;

            if ((state_nxt == state) &&
                (state == ST_SETTLE || state == ST_SAMPLE)) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end else begin
                cyc_cnt <= '0;
            end

            if (accept) begin
                shift_reg <= '0;
                eval_cnt  <= '0;
                flaky     <= 1'b0;
            end else if (state == ST_PACK) begin
                shift_reg <= shift_nxt;
                eval_cnt  <= eval_cnt + 1'b1;
                flaky     <= flaky_nxt;
            end

            if (state == ST_PACK && state_nxt == ST_OUT) begin
                resp_data  <= shift_nxt;
                resp_flaky <= flaky_nxt;
            end
        end
    end

endmodule
